// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
// Imported by the fetch queue and the fetch unit top level.
package fetch_unit_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int          FETCH_DEPTH      = 2;

    // Classification of a memory response in the cycle it arrives
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_DROP = 2'd1,
        RSP_KEEP = 2'd2
    } rsp_kind_e;

    // Counter width able to hold 0..depth inclusive
    function automatic int cnt_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; the head entry is readable combinationally.
// Used for the fetched-instruction queue and the in-flight address tags.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_bits(DEPTH);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign o_empty = (count_reg == '0);
    assign o_full  = (count_reg == CW'(DEPTH));
    assign o_count = count_reg;
    assign o_data  = mem_reg[rd_ptr_reg];

    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    // DEPTH is a power of two, so pointers wrap by plain overflow
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) begin
            mem_reg[wr_ptr_reg] <= i_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues in-order word fetches and queues returned
// instructions with their PC for the IF/ID handshake; EX redirects flush everything.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int               DEPTH    = FETCH_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic             i_imem_gnt,
    input  logic             i_imem_rvalid,
    input  logic [WIDTH-1:0] i_imem_rdata,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_pc,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_plus4
);

    localparam int CW = cnt_bits(DEPTH);
    localparam int QW = 2 * WIDTH;

    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_next;
    logic [CW-1:0]    outstanding_reg;
    logic [CW-1:0]    outstanding_next;
    logic [CW-1:0]    discard_reg;
    logic [CW-1:0]    discard_next;

    logic [QW-1:0]    q_head;
    logic             q_empty;
    logic             q_full;
    logic [CW-1:0]    q_count;
    logic [WIDTH-1:0] tag_head;
    logic             tag_empty;
    logic             tag_full;
    logic [CW-1:0]    tag_count;

    logic             pop;
    logic             grant;
    logic             push;
    logic [CW:0]      in_use;
    rsp_kind_e        rsp_kind;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^i_redirect_pc[1:0];

    assign o_valid    = i_rst_n & ~q_empty;
    assign o_instr    = o_valid ? q_head[WIDTH-1:0] : WIDTH'(NOP_INSTR);
    assign o_pc       = o_valid ? q_head[QW-1:WIDTH] : '0;
    assign o_pc_plus4 = o_pc + WIDTH'(4);

    assign pop = o_valid & i_ready & ~i_redirect;

    // Slots already claimed: queued words plus every word still owed by memory
    assign in_use      = {1'b0, q_count} + {1'b0, outstanding_reg} - (CW + 1)'(pop);
    assign o_imem_req  = i_rst_n & ~i_redirect & (in_use < (CW + 1)'(DEPTH));
    assign o_imem_addr = pc_reg;
    assign grant       = o_imem_req & i_imem_gnt;

    always_comb begin
        rsp_kind = RSP_NONE;
        if (i_imem_rvalid) begin
            rsp_kind = (i_redirect || discard_reg != '0) ? RSP_DROP : RSP_KEEP;
        end
    end

    assign push = (rsp_kind == RSP_KEEP);

    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg + CW'(grant) - CW'(i_imem_rvalid);
        discard_next     = discard_reg;
        if (i_redirect) begin
            pc_next      = {i_redirect_pc[WIDTH-1:2], 2'b00};
            discard_next = outstanding_reg - CW'(i_imem_rvalid);
        end else begin
            if (grant) begin
                pc_next = pc_reg + WIDTH'(4);
            end
            if (i_imem_rvalid && discard_reg != '0) begin
                discard_next = discard_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

    // Tags stay in step with outstanding requests, so stale responses still retire one
    fetch_fifo #(
        .W     (WIDTH),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (1'b0),
        .i_push  (grant),
        .i_data  (pc_reg),
        .i_pop   (i_imem_rvalid),
        .o_data  (tag_head),
        .o_empty (tag_empty),
        .o_full  (tag_full),
        .o_count (tag_count)
    );

    fetch_fifo #(
        .W     (QW),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_redirect),
        .i_push  (push),
        .i_data  ({tag_head, i_imem_rdata}),
        .i_pop   (pop),
        .o_data  (q_head),
        .o_empty (q_empty),
        .o_full  (q_full),
        .o_count (q_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(push && q_full && !pop));
            assert (!(i_imem_rvalid && tag_empty));
            assert (!(grant && tag_full && !i_imem_rvalid));
            assert (tag_count == outstanding_reg);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomised checks of the fetch unit against an in-order memory model
// and a PC scoreboard.
module tb_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int errors = 0;
    int checks = 0;

    fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_instr       (instr),
        .o_pc          (pc),
        .o_pc_plus4    (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory model: in-order responses, configurable grant and latency
    int unsigned cyc = 0;
    int unsigned fixed_lat = 1;
    bit          rand_gnt = 0;
    bit          rand_lat = 0;
    logic [31:0] pend_addr[$];
    int unsigned pend_due[$];
    bit          acc_s;
    bit          resp_s;
    logic [31:0] acc_addr_s;

    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    end

    always @(negedge clk) begin
        acc_s      = imem_req & imem_gnt;
        acc_addr_s = imem_addr;
        resp_s     = imem_rvalid;
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
        end else begin
            if (resp_s && pend_addr.size() != 0) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (acc_s) begin
                pend_addr.push_back(acc_addr_s);
                pend_due.push_back(cyc + (rand_lat ? $urandom_range(1, 4) : fixed_lat) - 1);
            end
            check("mem_outstanding_bound", 32'(pend_addr.size() <= DEPTH), 32'd1);
        end
        imem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] exp_pc;
    bit          seen_req;
    bit          got;
    int          pops;

    initial begin
        rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;

        // Reset state
        repeat (3) step();
        check("rst_valid", valid, 1'b0);
        check("rst_req", imem_req, 1'b0);
        check("rst_instr", instr, NOP);
        check("rst_pc", pc, 32'h0);

        // Release with always-grant, 1-cycle memory, consumer always ready
        rst_n = 1'b1;
        #1;
        check("t1_req0", imem_req, 1'b1);
        check("t1_addr0", imem_addr, 32'h0);
        step();
        check("t1_valid_e1", valid, 1'b0);
        check("t1_addr1", imem_addr, 32'h4);
        step();
        check("t1_valid_e2", valid, 1'b1);
        check("t1_pc_first", pc, 32'h0);
        check("t1_plus4_first", pc_plus4, 32'h4);
        check("t1_instr_first", instr, mem_word(32'h0));
        check("t1_addr2", imem_addr, 32'h8);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t1_pc_seq", pc, 32'(4 * k));
            check("t1_instr_seq", instr, mem_word(32'(4 * k)));
            check("t1_addr_seq", imem_addr, 32'(4 * k + 8));
        end

        // Back-pressure: consumer stalled for 5 cycles after a fresh reset
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1; ready = 1'b0;
        #1;
        check("t2_addr0", imem_addr, 32'h0);
        step();
        check("t2_req_e1", imem_req, 1'b1);
        check("t2_addr_e1", imem_addr, 32'h4);
        step();
        check("t2_valid_e2", valid, 1'b1);
        check("t2_req_full", imem_req, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t2_hold_pc", pc, 32'h0);
            check("t2_hold_instr", instr, mem_word(32'h0));
            check("t2_hold_req", imem_req, 1'b0);
        end
        ready = 1'b1;
        #1;
        check("t2_req_resume", imem_req, 1'b1);
        check("t2_addr_resume", imem_addr, 32'h8);
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t2_pc_seq", pc, 32'(4 * k));
            check("t2_instr_seq", instr, mem_word(32'(4 * k)));
            check("t2_addr_seq", imem_addr, 32'(4 * k + 8));
        end

        // Redirect coinciding with a response and a ready consumer; target near wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        #1;
        check("t4_req_blocked", imem_req, 1'b0);
        check("t4_head_before", pc, 32'd24);
        step();
        redirect = 1'b0;
        #1;
        check("t4_flushed", valid, 1'b0);
        check("t4_addr_target", imem_addr, 32'hFFFF_FFFC);
        step();
        check("t4_valid_e1", valid, 1'b0);
        check("t4_addr_wrap", imem_addr, 32'h0);
        step();
        check("t4_valid_e2", valid, 1'b1);
        check("t4_pc_target", pc, 32'hFFFF_FFFC);
        check("t4_plus4_wrap", pc_plus4, 32'h0);
        check("t4_instr_target", instr, mem_word(32'hFFFF_FFFC));
        step();
        check("t4_pc_after_wrap", pc, 32'h0);
        check("t4_plus4_after_wrap", pc_plus4, 32'h4);

        // Redirect to 0x103 with two requests in flight (3-cycle memory)
        rst_n = 1'b0; fixed_lat = 3;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("t3_req_e1", imem_req, 1'b1);
        check("t3_addr_e1", imem_addr, 32'h4);
        step();
        check("t3_req_two_inflight", imem_req, 1'b0);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        #1;
        check("t3_addr_aligned", imem_addr, 32'h100);
        seen_req = 0; got = 0;
        for (int n = 0; n < 30 && !got; n++) begin
            if (imem_req && !seen_req) begin
                check("t3_first_req_addr", imem_addr, 32'h100);
                seen_req = 1;
            end
            if (valid) begin
                check("t3_pc_first", pc, 32'h100);
                check("t3_instr_first", instr, mem_word(32'h100));
                got = 1;
            end
            if (!got) step();
        end
        check("t3_valid_within_budget", 32'(got), 32'd1);

        // Random grant, latency, stalls and redirects against a PC scoreboard
        rst_n = 1'b0; rand_gnt = 1; rand_lat = 1;
        step();
        step();
        rst_n = 1'b1; exp_pc = 32'h0; pops = 0;
        for (int n = 0; n < 3000; n++) begin
            if (valid) begin
                check("rnd_pc", pc, exp_pc);
                check("rnd_instr", instr, mem_word(exp_pc));
            end
            check("rnd_align", imem_addr & 32'h3, 32'h0);
            ready    = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
            if (redirect) begin
                exp_pc = redirect_pc & ~32'h3;
            end else if (valid && ready) begin
                exp_pc = exp_pc + 32'h4;
                pops++;
            end
            step();
        end
        redirect = 1'b0; ready = 1'b0;
        check("rnd_progress", 32'(pops > 200), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
